uart_tx_toggle: RTL and testbench
=================================

// Module: uart_tx_toggle
// PURPOSE
//  Byte-serial UART transmitter for the averaged-ADC readout path. Captures bytes offered by the frame builder via a
//  toggle handshake (uart_en flips once per byte), buffers them in a small FIFO and shifts them out 8N1, LSB first.
//  Runs in the 40 MHz sample-clock domain; txd drives the board UART pin directly.
// PARAMETERS
//  CLK_HZ     40000000  input clock frequency
//  BAUD       115200    line rate; DIV = (CLK_HZ + BAUD/2)/BAUD = 347 clocks per bit
//  DEPTH      8         byte buffer depth, power of 2, >= 2
// PORTS
//  clk_40M    in   1    system clock
//  rst_n      in   1    reset, synchronous, active-low
//  txd_in     in   8    byte to send, valid in the cycle uart_en changes level
//  uart_en    in   1    toggle strobe: each level change (either direction) offers one byte
//  txd        out  1    serial line, idle high
//  busy       out  1    1 while a frame is on the line or the buffer is non-empty
//  ovf        out  1    sticky: a byte was offered while the buffer was full
//  level      out  4    buffer occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset: synchronous, active-low. The following values load on the first clk_40M edge with rst_n=0.
//   - txd=1, busy=0, ovf=0, level=0; FSM=IDLE; baud counter=0.
//   - en_q <= uart_en, so releasing reset never produces a spurious event.
//  Capture:
//   - en_q registers uart_en every cycle; push = uart_en ^ en_q (combinational).
//   - On a push edge, txd_in is written to the buffer. Toggles on consecutive cycles give consecutive pushes.
//   - Push while full (level==DEPTH) with no pop in that cycle: byte dropped, ovf<=1, held until reset.
//   - Push and pop in the same cycle while full: push accepted, level unchanged.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE/START.
//   - IDLE: if level!=0, pop into shift register, go to START. txd=1.
//   - START: txd=0 for DIV clocks.
//   - DATA: txd=sh[0] for DIV clocks per bit, shift right, 8 bits (bit counter 0..7).
//   - STOP: txd=1 for DIV clocks.
//   - At the end of STOP: pop and go straight to START if level!=0; otherwise go to IDLE. Back-to-back frames
//     therefore have no idle gap.
//  Timing:
//   - Baud counter runs 0..DIV-1 inside each bit and restarts at 0 on every state change.
//   - Latency: toggle sampled at edge N (empty, IDLE) -> popped at edge N+1 -> txd=0 from edge N+2.
//   - Frame length is exactly 10*DIV = 3470 clocks (11*DIV with parity).
//  Status outputs:
//   - level updates on the same edge as push/pop.
//   - busy = (state!=IDLE) | (level!=0), registered.
// CONFIGURATION
//  UART_TX_PARITY_EN defined:
//   - PARITY state between DATA and STOP; txd = ^byte (even parity) for DIV clocks.
//   - Frame length becomes 11*DIV.
//  UART_TX_PARITY_EN undefined:
//   - No PARITY state; DATA goes to STOP; 8N1.
// STRUCTURE
//  Package uart_tx_pkg:
//   - state typedef (IDLE, START, DATA, PARITY, STOP);
//   - function calc_div(CLK_HZ, BAUD);
//   - localparam FRAME_BITS (10, or 11 with parity).
//  Sub-module uart_byte_fifo:
//   - synchronous FWFT, DEPTH x 8, ports push/pop/din/dout/level/full/empty;
//   - overflow policy stays in the parent.
//  Top level: toggle detect, baud counter, bit counter, shift register, FSM.
// TESTING
//  1. Hold rst_n=0 for 3 clocks -> txd=1, busy=0, ovf=0, level=0; release with uart_en=1 -> no frame starts.
//  2. Toggle with txd_in=8'hA5 -> txd low 347 clk, then 1,0,1,0,0,1,0,1 at 347 clk each, then high; busy=0 at +3471.
//  3. Toggles on two consecutive cycles with 8'hFE then 8'hA5 -> both frames sent with no idle gap; 6940 clk total.
//  4. DEPTH=8, ten toggles on consecutive cycles:
//     - first byte popped immediately, next eight buffered (level=8), tenth dropped -> ovf=1;
//     - exactly 9 frames appear on txd.
//  5. rst_n=0 mid-DATA of 8'h33 -> txd=1 on that edge, level=0, busy=0; no residual frame after release.
//  6. With UART_TX_PARITY_EN defined, send 8'h33 then 8'h07:
//     - parity bits are 0 and 1 respectively;
//     - each frame is 3817 clocks.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the toggle-strobed UART transmitter.
// Defining UART_TX_PARITY_EN adds an even-parity bit to every frame.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    // Clocks per bit, rounded to nearest.
    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

`ifdef UART_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif

endpackage

// File: rtl/uart_byte_fifo.sv
// First-word-fall-through byte buffer, DEPTH x 8 (DEPTH a power of 2).
// Ignores push when full without pop and pop when empty; overflow reporting lives in the parent.
module uart_byte_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q;
    logic          wr, rd;

    assign full  = (count_q == FULL_LVL);
    assign empty = (count_q == '0);
    assign wr    = push & (~full | pop);
    assign rd    = pop & ~empty;
    assign dout  = mem[rptr_q];
    assign level = count_q;

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (rd) begin
                rptr_q <= rptr_q + 1'b1;
            end
            count_q <= count_q + (AW + 1)'(wr) - (AW + 1)'(rd);
        end
    end

endmodule

// File: rtl/uart_tx_toggle.sv
// Toggle-strobed byte capture into a FIFO, shifted out 8N1 LSB first (8E1 when
// UART_TX_PARITY_EN is defined). Frames go back to back while the buffer holds data.
module uart_tx_toggle
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLK_HZ = 40000000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                   clk_40M,
    input  logic                   rst_n,
    input  logic [7:0]             txd_in,
    input  logic                   uart_en,
    output logic                   txd,
    output logic                   busy,
    output logic                   ovf,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned DIV = calc_div(CLK_HZ, BAUD);
    localparam int unsigned CW  = $clog2(DIV);
    localparam int unsigned LW  = $clog2(DEPTH) + 1;

`ifdef UART_TX_PARITY_EN
    localparam state_e AfterData = StParity;
`else
    localparam state_e AfterData = StStop;
`endif

    logic          en_q;
    logic          push, push_ok, pop;
    logic [7:0]    dout;
    logic [LW-1:0] fifo_level, level_d;
    logic          full, empty;

    state_e        state_q, state_d;
    logic [CW-1:0] baud_q;
    logic          baud_end;
    logic [2:0]    bit_q;
    logic [7:0]    sh_q;
    logic          par_q;
    logic          txd_d, txd_q, busy_q, ovf_q;

    // Loaded in reset too, so releasing reset never looks like a toggle.
    always_ff @(posedge clk_40M) begin
        en_q <= uart_en;
    end

    assign push     = uart_en ^ en_q;
    assign push_ok  = push & (~full | pop);
    assign level_d  = fifo_level + LW'(push_ok) - LW'(pop);
    assign baud_end = (baud_q == CW'(DIV - 1));

    uart_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_40M),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (txd_in),
        .dout  (dout),
        .level (fifo_level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk_40M) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = StStart;
                end
            end
            StStart:  if (baud_end) state_d = StData;
            StData:   if (baud_end && bit_q == 3'd7) state_d = AfterData;
            StParity: if (baud_end) state_d = StStop;
            StStop: begin
                if (baud_end) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        txd_d = 1'b1;
        unique case (state_q)
            StStart:  txd_d = 1'b0;
            StData:   txd_d = sh_q[0];
            StParity: txd_d = par_q;
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_40M) begin
        if (!rst_n) begin
            baud_q <= '0;
            bit_q  <= '0;
            sh_q   <= '0;
            par_q  <= 1'b0;
            txd_q  <= 1'b1;
            busy_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            // Restart on every state change and at each bit boundary.
            if (state_d != state_q || baud_end || state_q == StIdle) begin
                baud_q <= '0;
            end else begin
                baud_q <= baud_q + 1'b1;
            end
            if (state_q != StData) begin
                bit_q <= '0;
            end else if (baud_end) begin
                bit_q <= bit_q + 3'd1;
            end
            if (pop) begin
                sh_q  <= dout;
                par_q <= ^dout;
            end else if (state_q == StData && baud_end) begin
                sh_q <= {1'b0, sh_q[7:1]};
            end
            txd_q  <= txd_d;
            busy_q <= (state_d != StIdle) || (level_d != '0);
            if (push && full && !pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign txd   = txd_q;
    assign busy  = busy_q;
    assign ovf   = ovf_q;
    assign level = fifo_level;

endmodule

// File: tb/tb_uart_tx_toggle.sv
// Self-checking bench for uart_tx_toggle; expected line waveforms come from frame arithmetic.
// Build with UART_TX_PARITY_EN defined to exercise the parity variant.
module tb_uart_tx_toggle;

    localparam int DIV = 347;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       uart_en;
    logic [7:0] txd_in;
    logic       txd, busy, ovf;
    logic [3:0] level;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic [9:0] line;  // 8N1 line bits, index 0 = start bit
    } vec_t;

    vec_t        vecs [3];
    logic [10:0] frames_q [$];

    uart_tx_toggle dut (
        .clk_40M (clk),
        .rst_n   (rst_n),
        .txd_in  (txd_in),
        .uart_en (uart_en),
        .txd     (txd),
        .busy    (busy),
        .ovf     (ovf),
        .level   (level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offered byte is sampled on the next edge; returns just after that edge.
    task automatic offer(input logic [7:0] b);
        uart_en = ~uart_en;
        txd_in  = b;
        tick();
    endtask

    function automatic logic [10:0] build_frame(input logic [7:0] b);
        logic [10:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i + 1] = b[i];
`ifdef UART_TX_PARITY_EN
        f[9] = ^b;
`endif
        f[FB - 1] = 1'b1;
        return f;
    endfunction

    function automatic logic [10:0] frame_from_vec(input vec_t v);
        logic [10:0] f;
        f      = '1;
        f[8:0] = v.line[8:0];
`ifdef UART_TX_PARITY_EN
        f[9]  = v.par;
        f[10] = v.line[9];
`else
        f[9]  = v.line[9];
`endif
        return f;
    endfunction

    // Compares txd cycle by cycle against queued frames starting at cycle s, then idle.
    task automatic check_line(input int s);
        int nf, total, stop_t, t, f, k;
        int bad [$];
        int bad_tail, bad_busy;
        logic e;
        nf       = frames_q.size();
        total    = nf * FB * DIV;
        stop_t   = s + total + 8;
        bad_tail = 0;
        bad_busy = 0;
        for (int i = 0; i < nf; i++) bad.push_back(0);
        while (cyc < stop_t) begin
            tick();
            t = cyc;
            e = 1'b1;
            f = 0;
            if (t >= s && t < s + total) begin
                f = (t - s) / (FB * DIV);
                k = ((t - s) % (FB * DIV)) / DIV;
                e = frames_q[f][k];
            end
            if (txd !== e) begin
                if (t >= s && t < s + total) bad[f]++;
                else bad_tail++;
            end
            if (busy !== (t < s - 1 + total)) bad_busy++;
        end
        for (int i = 0; i < nf; i++) check($sformatf("frame%0d_bad_cycles", i), bad[i], 0);
        check("line_idle_bad_cycles", bad_tail, 0);
        check("busy_span_bad_cycles", bad_busy, 0);
        frames_q.delete();
    endtask

    initial begin
        int n, low, bz, nb;
        logic [7:0] b;

        rst_n   = 1'b0;
        uart_en = 1'b0;
        txd_in  = 8'h00;
        tick();
        uart_en = 1'b1;
        tick();
        tick();
        check("rst_txd", txd, 1);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);
        check("rst_level", level, 0);
        rst_n = 1'b1;
        low = 0;
        bz  = 0;
        repeat (30) begin
            tick();
            if (txd !== 1'b1) low++;
            if (busy !== 1'b0) bz++;
        end
        check("release_txd_low_cycles", low, 0);
        check("release_busy_cycles", bz, 0);
        check("release_level", level, 0);

        vecs[0] = '{8'hA5, 1'b0, 10'b1_10100101_0};
        vecs[1] = '{8'h33, 1'b0, 10'b1_00110011_0};
        vecs[2] = '{8'h07, 1'b1, 10'b1_00000111_0};
        for (int i = 0; i < 3; i++) begin
            offer(vecs[i].data);
            n = cyc;
            check($sformatf("vec%0d_level", i), level, 1);
            check($sformatf("vec%0d_busy", i), busy, 1);
            frames_q.push_back(frame_from_vec(vecs[i]));
            check_line(n + 2);
        end

        // Two bytes on consecutive cycles: back-to-back frames.
        offer(8'hFE);
        n = cyc;
        offer(8'hA5);
        check("b2b_level", level, 1);
        frames_q.push_back(build_frame(8'hFE));
        frames_q.push_back(build_frame(8'hA5));
        check_line(n + 2);

        // Ten toggles: one popped, eight buffered, tenth dropped.
        n = 0;
        for (int i = 0; i < 10; i++) begin
            b = 8'(8'h10 + i * 7);
            offer(b);
            if (i == 0) n = cyc;
            if (i < 9) frames_q.push_back(build_frame(b));
            if (i == 8) begin
                check("fill_level", level, 8);
                check("fill_ovf", ovf, 0);
            end
            if (i == 9) begin
                check("drop_level", level, 8);
                check("drop_ovf", ovf, 1);
            end
        end
        check_line(n + 2);
        check("ovf_sticky", ovf, 1);

        // Reset in the middle of a data bit with a byte still buffered.
        offer(8'h33);
        n = cyc;
        offer(8'h55);
        while (cyc < n + 2 + 3 * DIV) tick();
        rst_n = 1'b0;
        tick();
        check("midrst_txd", txd, 1);
        check("midrst_level", level, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ovf", ovf, 0);
        tick();
        rst_n = 1'b1;
        low = 0;
        bz  = 0;
        repeat (4000) begin
            tick();
            if (txd !== 1'b1) low++;
            if (busy !== 1'b0) bz++;
        end
        check("midrst_residual_low", low, 0);
        check("midrst_residual_busy", bz, 0);

        // Random bursts with small gaps.
        for (int burst = 0; burst < 2; burst++) begin
            nb = $urandom_range(1, 3);
            n  = 0;
            for (int j = 0; j < nb; j++) begin
                if (j > 0) repeat ($urandom_range(0, 3)) tick();
                b = 8'($urandom);
                offer(b);
                if (j == 0) n = cyc;
                frames_q.push_back(build_frame(b));
            end
            check($sformatf("rand%0d_level", burst), level, (nb == 1) ? 1 : nb - 1);
            check_line(n + 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
